alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one instance of the single-cycle 32-bit `alu` between two requesters (e.g. integer execute path and branch-compare path) using round-robin arbitration. Each accepted operation is captured, run through the ALU for one cycle, and returned on a single registered response channel with backpressure. It sits between the decode/issue logic and the ALU. The `alu_ctrl` encodings (`ALU_ADD` through `ALU_BGEU`) come from `riscv_pkg`.

## Interface
- `TAG_W`, 4: width of the opaque requester tag, returned unchanged with the response.
- `CNT_W`, 16: width of the completed-operation counter.

- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `r0_valid` input 1: requester 0 has an operation.
- `r0_ready` output 1: requester 0's operation is accepted this cycle.
- `r0_a` input 32: requester 0 operand a.
- `r0_b` input 32: requester 0 operand b.
- `r0_op` input 4: requester 0 ALU control code.
- `r0_tag` input TAG_W: requester 0 tag.
- `r1_valid`, `r1_ready`, `r1_a`, `r1_b`, `r1_op`, `r1_tag`: same widths and meaning, for requester 1.
- `rsp_valid` output 1: the response is valid.
- `rsp_ready` input 1: the consumer accepts the response.
- `rsp_id` output 1: index of the requester that issued the operation.
- `rsp_tag` output TAG_W: tag of the issuing request.
- `rsp_result` output 32: ALU result.
- `rsp_zero` output 1: ALU zero flag. For branch ops this is the branch-taken flag.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `op_count` output CNT_W: number of completed response handshakes.

## Operation
- **Accept:** a request transfers when `rX_valid && rX_ready`.
- **Requester rule:** a requester must hold `a`, `b`, `op` and `tag` stable while valid is high and must not drop valid before it is accepted.
- **FSM states:** IDLE, EXEC, RESP.
  - **IDLE:** if any valid is high, grant one requester, assert its ready, capture its a/b/op/tag/id into operand registers, and go to EXEC. Otherwise stay in IDLE.
  - **EXEC:** the operand registers drive the internal ALU. At the clock edge, register result, zero, tag and id into the response registers, set `rsp_valid`, and go to RESP.
  - **RESP:** hold all `rsp_*` outputs stable while `rsp_ready` is low.
    - On `rsp_valid && rsp_ready`: increment `op_count`.
    - If any valid is high in that same cycle, grant and capture (same rule as IDLE) and go to EXEC.
    - Otherwise clear `rsp_valid` and go to IDLE.
- **Ready generation:** `rX_ready = grant_X && (state==IDLE || (state==RESP && rsp_ready))`.
  - `rX_ready` is combinational on valid and `rsp_ready`.
  - At most one ready is high per cycle.
  - Ready is never high in EXEC.
- **Arbitration:**
  - With only one valid high, that requester wins.
  - With both valid high, the requester other than `last_grant` wins.
  - `last_grant` updates to the winner on every accept.
- **Opcodes:** no decoding is done here. Unused 4-bit codes pass straight to the ALU, and its output is returned as-is.
- **Counter:** `op_count` wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- **Latency:** a request accepted in cycle N has `rsp_valid` high from cycle N+2.
- **Throughput:** at most one operation per 2 cycles, reached when `rsp_ready` is held high and a valid is present in every RESP cycle.
- **Backpressure:** the response stays registered and unchanged for as many cycles as `rsp_ready` is low. No new request is accepted during that time.
- **Reset values:**
  - state = IDLE, `last_grant` = 1, so requester 0 wins the first contention.
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_zero` = 0, `rsp_id` = 0, `rsp_tag` = 0.
  - `busy` = 0, `op_count` = 0, both readies = 0.
- **Reset mid-operation:** any in-flight or pending response is discarded with no `rsp_valid` pulse. Requesters must re-present the dropped operation.
- **Simultaneous events:**
  - A response handshake and a new accept in the same RESP cycle are both honored.
  - `op_count` increments once per response handshake only, never per accept.

## Test plan
- **Single request:** reset, then r0 = (`ALU_ADD`, 0x12345678, 0x87654321, tag 3). Required: `r0_ready` pulses in cycle N; in N+2, `rsp_valid`=1, result 0x99999999, zero 0, id 0, tag 3; `op_count`=1 after the handshake.
- **Contention / round-robin:** r0 and r1 both hold valid with `rsp_ready`=1. r0 = (`ALU_SUB`, 0x12345678, 0x12345678), r1 = (`ALU_SLT`, 0x80000000, 0x7FFFFFFF). Required response order: id 0, result 0, zero 1; then id 1, result 1, zero 0; then id 0 again. Grants alternate on every accept.
- **Backpressure:** r1 = (`ALU_BEQ`, 0x12345678, 0x12345678, tag 9) with `rsp_ready` low for 5 cycles. Required: `rsp_*` stay stable at result 0, zero 1, tag 9; no readies are asserted; the next accept occurs in the cycle `rsp_ready` rises.
- **Back-to-back:** 4 consecutive r0 requests with `rsp_ready`=1. Required: accepts every 2 cycles; responses in order; `op_count`=4.
- **Reset mid-op:** assert `rst` in EXEC. Required: all outputs return to their reset values immediately; no response for the dropped operation; the next request completes normally.
- **Counter wrap:** with CNT_W=2, complete 5 operations. Required: `op_count` reads 1.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one single-cycle 32-bit ALU between two requesters using
//   round-robin arbitration. An accepted operation is captured into operand
//   registers, evaluated by the ALU for one cycle, and returned on a single
//   registered response channel that honours consumer backpressure.
//
// Parameters:
//   TAG_W  width of the opaque requester tag echoed back with the response
//   CNT_W  width of the completed-response counter (wraps silently)
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   r0_valid/r0_ready/r0_a/r0_b/r0_op/r0_tag   requester 0 channel
//   r1_valid/r1_ready/r1_a/r1_b/r1_op/r1_tag   requester 1 channel
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_tag                issuing requester index and its tag
//   rsp_result, rsp_zero           ALU result and zero / branch-taken flag
//   busy                           high whenever the FSM is not idle
//   op_count                       number of completed response handshakes
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r0_b,
    input  logic [3:0]       r0_op,
    input  logic [TAG_W-1:0] r0_tag,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r1_b,
    input  logic [3:0]       r1_op,
    input  logic [TAG_W-1:0] r1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic               lastGrant_q, lastGrant_d;
    logic [31:0]        opA_q, opA_d;
    logic [31:0]        opB_q, opB_d;
    logic [3:0]         opOp_q, opOp_d;
    logic [TAG_W-1:0]   opTag_q, opTag_d;
    logic               opId_q, opId_d;
    logic               rspValid_q, rspValid_d;
    logic               rspId_q, rspId_d;
    logic [TAG_W-1:0]   rspTag_q, rspTag_d;
    logic [31:0]        rspResult_q, rspResult_d;
    logic               rspZero_q, rspZero_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               grant0, grant1, canAccept, accept;
    logic [31:0]        aluResult, aluDiff;
    logic               aluZero, aluTaken, aluBranch;

    // The shared ALU, fed only from the captured operand registers. Branch
    // codes return a-b as the result and report the taken condition on the
    // zero flag; every other code reports whether the result is zero.
    always_comb begin
        aluDiff   = opA_q - opB_q;
        aluResult = 32'd0;
        aluTaken  = 1'b0;
        aluBranch = 1'b0;
        case (opOp_q)
            ALU_ADD:  aluResult = opA_q + opB_q;
            ALU_SUB:  aluResult = aluDiff;
            ALU_SLL:  aluResult = opA_q << opB_q[4:0];
            ALU_SLT:  aluResult = {31'd0, $signed(opA_q) < $signed(opB_q)};
            ALU_SLTU: aluResult = {31'd0, opA_q < opB_q};
            ALU_XOR:  aluResult = opA_q ^ opB_q;
            ALU_SRL:  aluResult = opA_q >> opB_q[4:0];
            ALU_SRA:  aluResult = $unsigned($signed(opA_q) >>> opB_q[4:0]);
            ALU_OR:   aluResult = opA_q | opB_q;
            ALU_AND:  aluResult = opA_q & opB_q;
            ALU_BEQ:  begin aluBranch = 1'b1; aluResult = aluDiff; aluTaken = (opA_q == opB_q); end
            ALU_BNE:  begin aluBranch = 1'b1; aluResult = aluDiff; aluTaken = (opA_q != opB_q); end
            ALU_BLT:  begin aluBranch = 1'b1; aluResult = aluDiff; aluTaken = ($signed(opA_q) < $signed(opB_q)); end
            ALU_BGE:  begin aluBranch = 1'b1; aluResult = aluDiff; aluTaken = ($signed(opA_q) >= $signed(opB_q)); end
            ALU_BLTU: begin aluBranch = 1'b1; aluResult = aluDiff; aluTaken = (opA_q < opB_q); end
            ALU_BGEU: begin aluBranch = 1'b1; aluResult = aluDiff; aluTaken = (opA_q >= opB_q); end
            default:  aluResult = 32'd0;
        endcase
        aluZero = aluBranch ? aluTaken : (aluResult == 32'd0);
    end

    // Arbitration and the next-state logic. The grant only matters when an
    // accept slot exists: in IDLE, or in RESP while the held response is being
    // taken. Reset gates the readies so nothing is offered while it is held.
    always_comb begin
        grant1    = (r0_valid && r1_valid) ? ~lastGrant_q : r1_valid;
        grant0    = r0_valid && !grant1;
        canAccept = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
        r0_ready  = grant0 && canAccept;
        r1_ready  = grant1 && canAccept;
        accept    = r0_ready || r1_ready;

        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        opOp_d      = opOp_q;
        opTag_d     = opTag_q;
        opId_d      = opId_q;
        rspValid_d  = rspValid_q;
        rspId_d     = rspId_q;
        rspTag_d    = rspTag_q;
        rspResult_d = rspResult_q;
        rspZero_d   = rspZero_q;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                rspValid_d  = 1'b1;
                rspId_d     = opId_q;
                rspTag_d    = opTag_q;
                rspResult_d = aluResult;
                rspZero_d   = aluZero;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    count_d    = count_q + CNT_W'(1);
                    rspValid_d = 1'b0;
                    state_d    = accept ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            lastGrant_d = r1_ready;
            opId_d      = r1_ready;
            opA_d       = r1_ready ? r1_a   : r0_a;
            opB_d       = r1_ready ? r1_b   : r0_b;
            opOp_d      = r1_ready ? r1_op  : r0_op;
            opTag_d     = r1_ready ? r1_tag : r0_tag;
        end
    end

    // State register. Reset discards any captured operation and any pending
    // response; last grant starts at requester 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            opA_q       <= 32'd0;
            opB_q       <= 32'd0;
            opOp_q      <= 4'd0;
            opTag_q     <= '0;
            opId_q      <= 1'b0;
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspTag_q    <= '0;
            rspResult_q <= 32'd0;
            rspZero_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            opOp_q      <= opOp_d;
            opTag_q     <= opTag_d;
            opId_q      <= opId_d;
            rspValid_q  <= rspValid_d;
            rspId_q     <= rspId_d;
            rspTag_q    <= rspTag_d;
            rspResult_q <= rspResult_d;
            rspZero_q   <= rspZero_d;
            count_q     <= count_d;
        end
    end

    assign rsp_valid  = rspValid_q;
    assign rsp_id     = rspId_q;
    assign rsp_tag    = rspTag_q;
    assign rsp_result = rspResult_q;
    assign rsp_zero   = rspZero_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter. Two instances share all inputs:
// the default one and one with a 2-bit counter to exercise counter wrap.
// Every cycle is compared against a transaction-level model that keeps a
// queue of expected responses, each with the cycle it becomes visible.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vecT;

    typedef struct {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] result;
        logic        zero;
        int          vis;
    } respT;

    logic        clk, rst;
    logic        r0Valid, r0Ready, r1Valid, r1Ready;
    logic [31:0] r0A, r0B, r1A, r1B;
    logic [3:0]  r0Op, r1Op, r0Tag, r1Tag;
    logic        rspValid, rspReady, rspId, rspZero, busy;
    logic [3:0]  rspTag;
    logic [31:0] rspResult;
    logic [15:0] opCount;
    logic        r0Ready2, r1Ready2, rspValid2, rspId2, rspZero2, busy2;
    logic [3:0]  rspTag2;
    logic [31:0] rspResult2;
    logic [1:0]  opCount2;

    int   total, bad, cyc, modelCount;
    logic modelLast, modelAcc0, modelAcc1;
    respT mq[$];
    vecT  vecs[16];
    int   acceptCyc[8];

    logic        seenR0Ready, seenR1Ready, seenRspValid, seenZero, seenId;
    logic [3:0]  seenTag;
    logic [31:0] seenResult;
    logic [15:0] seenCount;
    logic [1:0]  seenCount2;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0Valid), .r0_ready(r0Ready), .r0_a(r0A), .r0_b(r0B), .r0_op(r0Op), .r0_tag(r0Tag),
        .r1_valid(r1Valid), .r1_ready(r1Ready), .r1_a(r1A), .r1_b(r1B), .r1_op(r1Op), .r1_tag(r1Tag),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId), .rsp_tag(rspTag),
        .rsp_result(rspResult), .rsp_zero(rspZero), .busy(busy), .op_count(opCount)
    );

    alu_share_arbiter #(.TAG_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .r0_valid(r0Valid), .r0_ready(r0Ready2), .r0_a(r0A), .r0_b(r0B), .r0_op(r0Op), .r0_tag(r0Tag),
        .r1_valid(r1Valid), .r1_ready(r1Ready2), .r1_a(r1A), .r1_b(r1B), .r1_op(r1Op), .r1_tag(r1Tag),
        .rsp_valid(rspValid2), .rsp_ready(rspReady), .rsp_id(rspId2), .rsp_tag(rspTag2),
        .rsp_result(rspResult2), .rsp_zero(rspZero2), .busy(busy2), .op_count(opCount2)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, and reported on a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference ALU written from the operation definitions.
    function automatic void aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic z);
        longint sa, sb;
        logic   isBr, tk;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        isBr = (op >= ALU_BEQ);
        tk = 1'b0;
        r = 32'd0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = 32'(sa >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a - b;
        endcase
        case (op)
            ALU_BEQ:  tk = (a == b);
            ALU_BNE:  tk = (a != b);
            ALU_BLT:  tk = (sa < sb);
            ALU_BGE:  tk = (sa >= sb);
            ALU_BLTU: tk = (a < b);
            ALU_BGEU: tk = (a >= b);
            default:  tk = 1'b0;
        endcase
        z = isBr ? tk : (r == 32'd0);
    endfunction

    // Apply reset asynchronously, check every output at once, clear model.
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset_rsp_result", rspResult, 32'd0);
        checkOutput("reset_rsp_fields", 32'({rspZero, rspId, rspTag}), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_op_count", 32'(opCount), 32'd0);
        checkOutput("reset_readies", 32'({r0Ready, r1Ready}), 32'd0);
        checkOutput("reset_small_dut", 32'({opCount2, busy2, rspValid2, r0Ready2, r1Ready2}), 32'd0);
        mq.delete();
        modelLast  = 1'b1;
        modelCount = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Advance one cycle: sample on the falling edge, compare against the
    // model, then let the model absorb this cycle's handshakes.
    task automatic stepCycle();
        logic expRv, canAcc, g0, g1, e0, e1, eBusy, z;
        logic [31:0] r;
        respT n;
        @(negedge clk);
        expRv  = (mq.size() > 0) && (cyc >= mq[0].vis);
        eBusy  = (mq.size() > 0);
        canAcc = (mq.size() == 0) || (expRv && rspReady);
        g0 = 1'b0;
        g1 = 1'b0;
        if (r0Valid && r1Valid) begin
            if (modelLast) g0 = 1'b1; else g1 = 1'b1;
        end else if (r0Valid) g0 = 1'b1;
        else if (r1Valid) g1 = 1'b1;
        e0 = g0 && canAcc;
        e1 = g1 && canAcc;

        seenR0Ready  = r0Ready;
        seenR1Ready  = r1Ready;
        seenRspValid = rspValid;
        seenResult   = rspResult;
        seenZero     = rspZero;
        seenId       = rspId;
        seenTag      = rspTag;
        seenCount    = opCount;
        seenCount2   = opCount2;

        checkOutput("r0_ready", 32'(r0Ready), 32'(e0));
        checkOutput("r1_ready", 32'(r1Ready), 32'(e1));
        checkOutput("rsp_valid", 32'(rspValid), 32'(expRv));
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("op_count", 32'(opCount), 32'(modelCount[15:0]));
        checkOutput("op_count_w2", 32'(opCount2), 32'(modelCount[1:0]));
        checkOutput("small_dut_hs", 32'({r0Ready2, r1Ready2, rspValid2, busy2}), 32'({e0, e1, expRv, eBusy}));
        if (expRv) begin
            checkOutput("rsp_id", 32'(rspId), 32'(mq[0].id));
            checkOutput("rsp_tag", 32'(rspTag), 32'(mq[0].tag));
            checkOutput("rsp_result", rspResult, mq[0].result);
            checkOutput("rsp_zero", 32'(rspZero), 32'(mq[0].zero));
            checkOutput("small_dut_rsp", 32'({rspId2, rspTag2, rspZero2}), 32'({mq[0].id, mq[0].tag, mq[0].zero}));
            checkOutput("small_dut_result", rspResult2, mq[0].result);
        end

        if (expRv && rspReady) begin
            void'(mq.pop_front());
            modelCount++;
        end
        if (e0) begin
            aluRef(r0Op, r0A, r0B, r, z);
            n.id = 1'b0; n.tag = r0Tag; n.result = r; n.zero = z; n.vis = cyc + 2;
            mq.push_back(n);
            modelLast = 1'b0;
        end
        if (e1) begin
            aluRef(r1Op, r1A, r1B, r, z);
            n.id = 1'b1; n.tag = r1Tag; n.result = r; n.zero = z; n.vis = cyc + 2;
            mq.push_back(n);
            modelLast = 1'b1;
        end
        modelAcc0 = e0;
        modelAcc1 = e1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Issue one operation on requester 0 and wait (bounded) for its response.
    task automatic runOne(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                          output logic [31:0] res, output logic z, output logic got);
        got = 1'b0;
        res = 32'd0;
        z = 1'b0;
        r0Op = op; r0A = a; r0B = b; r0Tag = tag; r0Valid = 1'b1;
        r1Valid = 1'b0;
        rspReady = 1'b1;
        for (int i = 0; i < 12 && !got; i++) begin
            stepCycle();
            if (modelAcc0) r0Valid = 1'b0;
            if (seenRspValid && rspReady) begin
                got = 1'b1;
                res = seenResult;
                z = seenZero;
            end
        end
    endtask

    // Stream n requests on requester 0 with the consumer always ready.
    task automatic issueSeries(input int n);
        int issued;
        issued = 0;
        for (int k = 0; k < 8; k++) acceptCyc[k] = 0;
        rspReady = 1'b1;
        r1Valid = 1'b0;
        r0Op = ALU_ADD; r0A = $urandom; r0B = $urandom; r0Tag = 4'd0; r0Valid = 1'b1;
        for (int i = 0; i < 60 && modelCount < n; i++) begin
            stepCycle();
            if (modelAcc0) begin
                acceptCyc[issued] = cyc - 1;
                issued++;
                if (issued < n) begin
                    r0A = $urandom; r0B = $urandom; r0Tag = 4'(issued);
                end else begin
                    r0Valid = 1'b0;
                end
            end
        end
        checkOutput("series_completed", 32'(modelCount), 32'(n));
        stepCycle();
    endtask

    // Fill the ALU vector table; expected values worked out by hand.
    task automatic applyStimulus();
        vecs[0]  = '{ALU_ADD,  32'h12345678, 32'h87654321, 32'h99999999, 1'b0};
        vecs[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
        vecs[2]  = '{ALU_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 1'b0};
        vecs[3]  = '{ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
        vecs[4]  = '{ALU_SLTU, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b1};
        vecs[5]  = '{ALU_XOR,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0};
        vecs[6]  = '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
        vecs[7]  = '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
        vecs[8]  = '{ALU_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
        vecs[9]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[10] = '{ALU_BEQ,  32'h00000003, 32'h00000003, 32'h00000000, 1'b1};
        vecs[11] = '{ALU_BNE,  32'h00000003, 32'h00000003, 32'h00000000, 1'b0};
        vecs[12] = '{ALU_BLT,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
        vecs[13] = '{ALU_BGE,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[14] = '{ALU_BLTU, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[15] = '{ALU_BGEU, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    endtask

    // Main test sequence.
    initial begin
        logic [31:0] res;
        logic        z, got;
        int          nRsp, nAcc;
        logic [31:0] rspRes[3];
        logic        rspZ[3], rspI[3];
        logic        accId[8];

        total = 0; bad = 0; cyc = 0; modelCount = 0; modelLast = 1'b1;
        modelAcc0 = 1'b0; modelAcc1 = 1'b0;
        rst = 1'b1; rspReady = 1'b0;
        r0Valid = 1'b0; r0A = '0; r0B = '0; r0Op = '0; r0Tag = '0;
        r1Valid = 1'b0; r1A = '0; r1B = '0; r1Op = '0; r1Tag = '0;
        applyStimulus();
        @(posedge clk);
        #1;
        doReset();

        // Single request: latency and first response.
        r0Op = ALU_ADD; r0A = 32'h12345678; r0B = 32'h87654321; r0Tag = 4'd3; r0Valid = 1'b1;
        rspReady = 1'b1;
        stepCycle();
        checkOutput("single_ready_n", 32'(seenR0Ready), 32'd1);
        r0Valid = 1'b0;
        stepCycle();
        checkOutput("single_valid_n1", 32'(seenRspValid), 32'd0);
        stepCycle();
        checkOutput("single_valid_n2", 32'(seenRspValid), 32'd1);
        checkOutput("single_result", seenResult, 32'h99999999);
        checkOutput("single_id_tag_zero", 32'({seenId, seenTag, seenZero}), 32'({1'b0, 4'd3, 1'b0}));
        stepCycle();
        checkOutput("single_count", 32'(seenCount), 32'd1);

        // Table of ALU vectors.
        for (int i = 0; i < 16; i++) begin
            runOne(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), res, z, got);
            checkOutput($sformatf("vec%0d_got", i), 32'(got), 32'd1);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].res);
            checkOutput($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].zero));
        end

        // Contention: both requesters hold valid, grants must alternate.
        doReset();
        r0Op = ALU_SUB; r0A = 32'h12345678; r0B = 32'h12345678; r0Tag = 4'd1; r0Valid = 1'b1;
        r1Op = ALU_SLT; r1A = 32'h80000000; r1B = 32'h7FFFFFFF; r1Tag = 4'd2; r1Valid = 1'b1;
        rspReady = 1'b1;
        nRsp = 0; nAcc = 0;
        for (int k = 0; k < 3; k++) begin rspRes[k] = 32'hDEADBEEF; rspZ[k] = 1'bx; rspI[k] = 1'bx; end
        for (int i = 0; i < 20 && nRsp < 3; i++) begin
            stepCycle();
            if ((seenR0Ready || seenR1Ready) && nAcc < 8) begin
                accId[nAcc] = seenR1Ready;
                nAcc++;
            end
            if (seenRspValid && rspReady) begin
                rspRes[nRsp] = seenResult; rspZ[nRsp] = seenZero; rspI[nRsp] = seenId;
                nRsp++;
            end
        end
        r0Valid = 1'b0; r1Valid = 1'b0;
        checkOutput("rr_resp_count", 32'(nRsp), 32'd3);
        checkOutput("rr_first", {rspRes[0][29:0], rspI[0], rspZ[0]}, {30'd0, 1'b0, 1'b1});
        checkOutput("rr_second", {rspRes[1][29:0], rspI[1], rspZ[1]}, {30'd1, 1'b1, 1'b0});
        checkOutput("rr_third_id", 32'(rspI[2]), 32'd0);
        for (int k = 1; k < nAcc; k++)
            checkOutput("rr_alternate", 32'(accId[k]), 32'(!accId[k-1]));
        repeat (4) stepCycle();

        // Backpressure: response held for five cycles, no accepts meanwhile.
        doReset();
        r1Op = ALU_BEQ; r1A = 32'h12345678; r1B = 32'h12345678; r1Tag = 4'd9; r1Valid = 1'b1;
        rspReady = 1'b0;
        stepCycle();
        checkOutput("bp_accept", 32'(seenR1Ready), 32'd1);
        r1Valid = 1'b0;
        r0Op = ALU_ADD; r0A = 32'd7; r0B = 32'd8; r0Tag = 4'd4; r0Valid = 1'b1;
        stepCycle();
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput("bp_hold_valid", 32'(seenRspValid), 32'd1);
            checkOutput("bp_hold_rsp", {seenResult[26:0], seenZero, seenTag}, {27'd0, 1'b1, 4'd9});
            checkOutput("bp_no_ready", 32'({seenR0Ready, seenR1Ready}), 32'd0);
        end
        rspReady = 1'b1;
        stepCycle();
        checkOutput("bp_release_accept", 32'(seenR0Ready), 32'd1);
        r0Valid = 1'b0;
        repeat (4) stepCycle();

        // Back-to-back stream of four requests.
        doReset();
        issueSeries(4);
        for (int k = 1; k < 4; k++)
            checkOutput("b2b_spacing", 32'(acceptCyc[k] - acceptCyc[k-1]), 32'd2);
        checkOutput("b2b_count", 32'(seenCount), 32'd4);

        // Reset while an operation sits in EXEC.
        doReset();
        r0Op = ALU_ADD; r0A = 32'd1; r0B = 32'd2; r0Tag = 4'd5; r0Valid = 1'b1;
        rspReady = 1'b1;
        stepCycle();
        r0Valid = 1'b0;
        doReset();
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkOutput("midrst_no_pulse", 32'(seenRspValid), 32'd0);
        end
        runOne(ALU_ADD, 32'd1, 32'd2, 4'd5, res, z, got);
        checkOutput("midrst_after_got", 32'(got), 32'd1);
        checkOutput("midrst_after_result", res, 32'd3);

        // Counter wrap on the 2-bit instance.
        doReset();
        issueSeries(5);
        checkOutput("wrap_count_w2", 32'(seenCount2), 32'd1);
        checkOutput("wrap_count_w16", 32'(seenCount), 32'd5);

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            rspReady = ($urandom_range(9) < 7);
            stepCycle();
            if (modelAcc0) r0Valid = 1'b0;
            if (modelAcc1) r1Valid = 1'b0;
            if (!r0Valid && $urandom_range(1) == 1) begin
                r0Op = 4'($urandom); r0A = $urandom; r0B = $urandom; r0Tag = 4'($urandom); r0Valid = 1'b1;
            end
            if (!r1Valid && $urandom_range(1) == 1) begin
                r1Op = 4'($urandom); r1A = $urandom; r1B = $urandom; r1Tag = 4'($urandom); r1Valid = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
